// File: rtl/j_pixel_scanner.sv
// j_pixel_scanner: frame pixel-scan generator.
// After an accepted start, walks every pixel of the latched img_width x img_height frame and
// emits (col, row, pix_addr) beats over a valid/ready handshake. Addresses are built
// incrementally with adders only.
// Build option J_BLOCK_SCAN_EN: scan in 8x8 tiles (tiles left->right, strips top->bottom),
// dimensions must be nonzero multiples of 8, row_done pulses once per finished tile strip.
module j_pixel_scanner #(
    parameter int unsigned DIM_W  = 13,
    parameter int unsigned ADDR_W = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [DIM_W-1:0]  img_height,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DIM_W-1:0]  col,
    output logic [DIM_W-1:0]  row,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              row_done,
    output logic              frame_done,
    output logic              busy,
    output logic              cfg_err
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    localparam logic [DIM_W-1:0]  DimOne  = 1;
    localparam logic [ADDR_W-1:0] AddrOne = 1;

    state_e            state_q, state_d;
    logic [DIM_W-1:0]  width_q, width_d;
    logic [DIM_W-1:0]  height_q, height_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // Address of the first pixel of the current line (within the current tile in block mode).
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              valid_q, valid_d;
    logic              row_done_q, row_done_d;
    logic              frame_done_q, frame_done_d;
    logic              cfg_err_q, cfg_err_d;

    logic [ADDR_W-1:0] width_ext;
    logic              dims_ok;
    logic              xfer;
    logic              last_col;
    logic              last_row;

`ifdef J_BLOCK_SCAN_EN
    localparam logic [ADDR_W-1:0] AddrEight = 8;

    logic [ADDR_W-1:0] tile_base_q, tile_base_d;
    logic [ADDR_W-1:0] strip_base_q, strip_base_d;
    logic [ADDR_W-1:0] width_x8;
    logic              tile_x_end;
    logic              tile_y_end;

    assign width_x8   = width_ext << 3;
    // Tile origins sit on multiples of 8, so the low index bits are the in-tile offsets.
    assign tile_x_end = (col_q[2:0] == 3'd7);
    assign tile_y_end = (row_q[2:0] == 3'd7);
    assign dims_ok    = (img_width != '0) && (img_height != '0) &&
                        (img_width[2:0] == 3'd0) && (img_height[2:0] == 3'd0);
`else
    assign dims_ok    = (img_width != '0) && (img_height != '0);
`endif

    assign width_ext = ADDR_W'(width_q);
    assign xfer      = valid_q && out_ready;
    assign last_col  = (col_q == width_q - DimOne);
    assign last_row  = (row_q == height_q - DimOne);

    // Next-state: start/latch, scan stepping on each transfer, abort override last.
    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        col_d        = col_q;
        row_d        = row_q;
        addr_d       = addr_q;
        row_base_d   = row_base_q;
        valid_d      = valid_q;
        row_done_d   = 1'b0;
        frame_done_d = 1'b0;
        cfg_err_d    = cfg_err_q;
`ifdef J_BLOCK_SCAN_EN
        tile_base_d  = tile_base_q;
        strip_base_d = strip_base_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (dims_ok) begin
                        state_d    = StScan;
                        width_d    = img_width;
                        height_d   = img_height;
                        cfg_err_d  = 1'b0;
                        valid_d    = 1'b1;
                        col_d      = '0;
                        row_d      = '0;
                        addr_d     = '0;
                        row_base_d = '0;
`ifdef J_BLOCK_SCAN_EN
                        tile_base_d  = '0;
                        strip_base_d = '0;
`endif
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StScan: begin
                if (xfer) begin
`ifdef J_BLOCK_SCAN_EN
                    if (!tile_x_end) begin
                        col_d  = col_q + DimOne;
                        addr_d = addr_q + AddrOne;
                    end else if (!tile_y_end) begin
                        // Next line inside the same tile.
                        col_d      = {col_q[DIM_W-1:3], 3'b000};
                        row_d      = row_q + DimOne;
                        row_base_d = row_base_q + width_ext;
                        addr_d     = row_base_q + width_ext;
                    end else if (!last_col) begin
                        // Next tile to the right; col_q ends in 7 so +1 lands on its origin.
                        col_d       = col_q + DimOne;
                        row_d       = {row_q[DIM_W-1:3], 3'b000};
                        tile_base_d = tile_base_q + AddrEight;
                        row_base_d  = tile_base_q + AddrEight;
                        addr_d      = tile_base_q + AddrEight;
                    end else if (!last_row) begin
                        // Next strip of tiles.
                        col_d        = '0;
                        row_d        = row_q + DimOne;
                        strip_base_d = strip_base_q + width_x8;
                        tile_base_d  = strip_base_q + width_x8;
                        row_base_d   = strip_base_q + width_x8;
                        addr_d       = strip_base_q + width_x8;
                        row_done_d   = 1'b1;
                    end else begin
                        valid_d      = 1'b0;
                        row_done_d   = 1'b1;
                        frame_done_d = 1'b1;
                        state_d      = StDone;
                    end
`else
                    if (!last_col) begin
                        col_d  = col_q + DimOne;
                        addr_d = addr_q + AddrOne;
                    end else if (!last_row) begin
                        col_d      = '0;
                        row_d      = row_q + DimOne;
                        row_base_d = row_base_q + width_ext;
                        addr_d     = row_base_q + width_ext;
                        row_done_d = 1'b1;
                    end else begin
                        valid_d      = 1'b0;
                        row_done_d   = 1'b1;
                        frame_done_d = 1'b1;
                        state_d      = StDone;
                    end
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // abort wins over start and over a same-cycle transfer; cfg_err and dims are kept.
        if (abort) begin
            state_d      = StIdle;
            width_d      = width_q;
            height_d     = height_q;
            cfg_err_d    = cfg_err_q;
            valid_d      = 1'b0;
            row_done_d   = 1'b0;
            frame_done_d = 1'b0;
            col_d        = '0;
            row_d        = '0;
            addr_d       = '0;
            row_base_d   = '0;
`ifdef J_BLOCK_SCAN_EN
            tile_base_d  = '0;
            strip_base_d = '0;
`endif
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            width_q      <= '0;
            height_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            row_base_q   <= '0;
            valid_q      <= 1'b0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
`ifdef J_BLOCK_SCAN_EN
            tile_base_q  <= '0;
            strip_base_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            col_q        <= col_d;
            row_q        <= row_d;
            addr_q       <= addr_d;
            row_base_q   <= row_base_d;
            valid_q      <= valid_d;
            row_done_q   <= row_done_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
`ifdef J_BLOCK_SCAN_EN
            tile_base_q  <= tile_base_d;
            strip_base_q <= strip_base_d;
`endif
        end
    end

    assign out_valid  = valid_q;
    assign col        = col_q;
    assign row        = row_q;
    assign pix_addr   = addr_q;
    assign row_done   = row_done_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != StIdle);
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_j_pixel_scanner.sv
// Self-checking bench for j_pixel_scanner: stimulus pushes expected beats into a scoreboard
// queue from a loop-based reference model; a negedge monitor pops and compares.
module tb_j_pixel_scanner;

    localparam int DW = 13;
    localparam int AW = 26;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [DW-1:0] img_width;
    logic [DW-1:0] img_height;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] col;
    logic [DW-1:0] row;
    logic [AW-1:0] pix_addr;
    logic          row_done;
    logic          frame_done;
    logic          busy;
    logic          cfg_err;

    j_pixel_scanner #(.DIM_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .img_width  (img_width),
        .img_height (img_height),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .col        (col),
        .row        (row),
        .pix_addr   (pix_addr),
        .row_done   (row_done),
        .frame_done (frame_done),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int r;
        int a;
        bit rd;
        bit fd;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    ready_mode = 0;
    int    phase = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic bit legal(int w, int h);
`ifdef J_BLOCK_SCAN_EN
        return (w > 0) && (h > 0) && (w % 8 == 0) && (h % 8 == 0);
`else
        return (w > 0) && (h > 0);
`endif
    endfunction

    // Reference model: enumerate the frame in scan order, address = row*W + col.
    function automatic void push_frame(int w, int h);
        beat_t b;
`ifdef J_BLOCK_SCAN_EN
        for (int ty = 0; ty < h / 8; ty++)
            for (int tx = 0; tx < w / 8; tx++)
                for (int iy = 0; iy < 8; iy++)
                    for (int ix = 0; ix < 8; ix++) begin
                        b.c  = tx * 8 + ix;
                        b.r  = ty * 8 + iy;
                        b.a  = b.r * w + b.c;
                        b.rd = (tx == w / 8 - 1) && (iy == 7) && (ix == 7);
                        b.fd = b.rd && (ty == h / 8 - 1);
                        exp_q.push_back(b);
                    end
`else
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                b.c  = c;
                b.r  = r;
                b.a  = r * w + c;
                b.rd = (c == w - 1);
                b.fd = b.rd && (r == h - 1);
                exp_q.push_back(b);
            end
`endif
    endfunction

    function automatic int pick_dim(int hi);
`ifdef J_BLOCK_SCAN_EN
        return 8 * int'($urandom_range(1, 2));
`else
        return int'($urandom_range(1, hi));
`endif
    endfunction

    // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: out_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
        phase++;
    end

    // Monitor: pulse checks against the previous transfer, stall stability, beat compare.
    bit            pend_rd = 0;
    bit            pend_fd = 0;
    bit            stall_prev = 0;
    logic [DW-1:0] prev_col;
    logic [DW-1:0] prev_row;
    logic [AW-1:0] prev_addr;

    always @(negedge clk) begin : monitor
        beat_t b;
        if (rst) begin
            pend_rd    = 0;
            pend_fd    = 0;
            stall_prev = 0;
        end else begin
            chk("row_done", row_done, pend_rd);
            chk("frame_done", frame_done, pend_fd);
            pend_rd = 0;
            pend_fd = 0;
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_col", col, prev_col);
                chk("stall_row", row, prev_row);
                chk("stall_addr", pix_addr, prev_addr);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_col", col, b.c);
                    chk("beat_row", row, b.r);
                    chk("beat_addr", pix_addr, b.a);
                    if (!abort) begin
                        pend_rd = b.rd;
                        pend_fd = b.fd;
                    end
                end
            end
            stall_prev = out_valid && !out_ready && !abort;
            prev_col   = col;
            prev_row   = row;
            prev_addr  = pix_addr;
        end
    end

    task automatic issue_start(int w, int h);
        @(posedge clk);
        #1;
        img_width  = DW'(w);
        img_height = DW'(h);
        start      = 1'b1;
        if (legal(w, h)) push_frame(w, h);
        @(posedge clk);
        #1;
        start      = 1'b0;
        img_width  = DW'($urandom);
        img_height = DW'($urandom);
    endtask

    task automatic run_frame(int w, int h, int mode, bit inject);
        bit ok;
        int n;
        ok         = legal(w, h);
        ready_mode = mode;
        issue_start(w, h);
        chk("cfg_err_after_start", cfg_err, !ok);
        chk("busy_after_start", busy, ok);
        if (!ok) begin
            repeat (4) begin
                @(negedge clk);
                chk("no_beat_bad_cfg", out_valid, 0);
            end
            return;
        end
        n = 0;
        while (exp_q.size() != 0 && n < w * h * 4 + 64) begin
            // A start mid-scan must be ignored.
            if (inject && n == 2) begin
                start      = 1'b1;
                img_width  = DW'(8);
                img_height = DW'(8);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("frame_timeout", exp_q.size(), 0);
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            exp_q.delete();
            return;
        end
        @(negedge clk);
        chk("busy_in_done", busy, 1);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("valid_after_done", out_valid, 0);
    endtask

    initial begin
        int aw;
        int ah;
        int n;
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        img_width  = '0;
        img_height = '0;
        out_ready  = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_col", col, 0);
        chk("rst_row", row, 0);
        chk("rst_addr", pix_addr, 0);
        chk("rst_row_done", row_done, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_frame(4, 3, 0, 0);
        run_frame(4, 2, 1, 0);
        run_frame(0, 5, 0, 0);
        run_frame(1, 1, 0, 0);
        run_frame(16, 8, 2, 0);
        run_frame(12, 8, 0, 0);

        // Abort together with a transfer at col=3,row=2.
`ifdef J_BLOCK_SCAN_EN
        aw = 16;
        ah = 16;
`else
        aw = 10;
        ah = 10;
`endif
        ready_mode = 0;
        issue_start(aw, ah);
        n = 0;
        while (!(out_valid && col == 3 && row == 2) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_point_reached", n < 500, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_col", col, 0);
        chk("abort_row", row, 0);
        chk("abort_addr", pix_addr, 0);
        @(negedge clk);
`ifdef J_BLOCK_SCAN_EN
        run_frame(8, 8, 0, 0);
`else
        run_frame(3, 2, 0, 0);
`endif

        run_frame(8191, 2, 0, 0);

        for (int i = 0; i < 8; i++) begin
            run_frame(pick_dim(6), pick_dim(5), 2, (i % 2) == 1);
        end

        // Reset in the middle of a scan.
        ready_mode = 0;
        issue_start(8, 8);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", pix_addr, 0);
        chk("midrst_row_done", row_done, 0);
        @(negedge clk);
        rst = 1'b0;
        run_frame(2, 2, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
